// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU definitions: memory-op encoding, ExcCodes, address map
package cpu_defs;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LW   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LHU  = 4'd3,
    MEM_LB   = 4'd4,
    MEM_LBU  = 4'd5,
    MEM_SW   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SB   = 4'd8
  } mem_op_e;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] DM_END_DEF   = 32'h0000_2FFF;
  localparam logic [31:0] TC0_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE_DEF = 32'h0000_7F10;
  localparam logic [31:0] IG_BASE_DEF  = 32'h0000_7F20;

  localparam logic [31:0] TC_WIN_LAST = 32'd11;
  localparam logic [31:0] IG_WIN_LAST = 32'd3;
  localparam logic [31:0] TC_COUNT_OFS = 32'd8;

endpackage

// File: rtl/mem_addr_check.sv
// rtl/mem_addr_check.sv - combinational load/store address fault detection
module mem_addr_check
  import cpu_defs::*;
#(
  parameter logic [31:0] DM_END   = DM_END_DEF,
  parameter logic [31:0] TC0_BASE = TC0_BASE_DEF,
  parameter logic [31:0] TC1_BASE = TC1_BASE_DEF,
  parameter logic [31:0] IG_BASE  = IG_BASE_DEF
) (
  input  logic [31:0] addr,
  input  logic [3:0]  mem_op,
  input  logic        ovf,
  output logic        adel,
  output logic        ades
);

  logic is_load, is_store, is_word, is_half;
  logic in_dm, in_tc0, in_tc1, in_ig, in_dev;
  logic misaligned, count_write, fault;

  always_comb begin
    is_load  = mem_op inside {MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU};
    is_store = mem_op inside {MEM_SW, MEM_SH, MEM_SB};
    is_word  = mem_op inside {MEM_LW, MEM_SW};
    is_half  = mem_op inside {MEM_LH, MEM_LHU, MEM_SH};

    in_dm  = addr <= DM_END;
    in_tc0 = (addr >= TC0_BASE) && (addr <= TC0_BASE + TC_WIN_LAST);
    in_tc1 = (addr >= TC1_BASE) && (addr <= TC1_BASE + TC_WIN_LAST);
    in_ig  = (addr >= IG_BASE)  && (addr <= IG_BASE + IG_WIN_LAST);
    in_dev = in_tc0 || in_tc1 || in_ig;

    misaligned  = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
    // Timer COUNT registers are read-only
    count_write = (mem_op == MEM_SW) &&
                  ((addr == TC0_BASE + TC_COUNT_OFS) || (addr == TC1_BASE + TC_COUNT_OFS));

    fault = ovf || misaligned || !(in_dm || in_dev) || (in_dev && !is_word) || count_write;

    adel = is_load && fault;
    ades = is_store && fault;
  end

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with Ov/AdEL/AdES exception resolution
module ex_mem_reg
  import cpu_defs::*;
#(
  parameter logic [31:0] DM_END   = DM_END_DEF,
  parameter logic [31:0] TC0_BASE = TC0_BASE_DEF,
  parameter logic [31:0] TC1_BASE = TC1_BASE_DEF,
  parameter logic [31:0] IG_BASE  = IG_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] in_pc,
  input  logic        in_bd,
  input  logic        in_exc_vld,
  input  logic [4:0]  in_exc_code,
  input  logic        in_ov_chk,
  input  logic [3:0]  in_mem_op,
  input  logic [31:0] in_alu_res,
  input  logic        in_alu_ovf,
  input  logic [31:0] in_rt_data,
  input  logic [4:0]  in_wr_reg,
  output logic [31:0] out_pc,
  output logic        out_bd,
  output logic [31:0] out_alu_res,
  output logic [31:0] out_rt_data,
  output logic [4:0]  out_wr_reg,
  output logic [3:0]  out_mem_op,
  output logic        out_exc_vld,
  output logic [4:0]  out_exc_code
);

  logic        adel, ades;
  logic        exc_now;
  logic [4:0]  code_now;

  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rt_q, rt_d;
  logic [4:0]  wr_q, wr_d;
  logic [3:0]  op_q, op_d;
  logic        exc_q, exc_d;
  logic [4:0]  code_q, code_d;

  mem_addr_check #(
    .DM_END  (DM_END),
    .TC0_BASE(TC0_BASE),
    .TC1_BASE(TC1_BASE),
    .IG_BASE (IG_BASE)
  ) u_addr_check (
    .addr  (in_alu_res),
    .mem_op(in_mem_op),
    .ovf   (in_alu_ovf),
    .adel  (adel),
    .ades  (ades)
  );

  always_comb begin
    exc_now  = 1'b1;
    code_now = EXC_INT;
    if (in_exc_vld)                  code_now = in_exc_code;
    else if (in_ov_chk && in_alu_ovf) code_now = EXC_OV;
    else if (adel)                   code_now = EXC_ADEL;
    else if (ades)                   code_now = EXC_ADES;
    else                             exc_now  = 1'b0;
  end

  always_comb begin
    pc_d   = pc_q;
    bd_d   = bd_q;
    alu_d  = alu_q;
    rt_d   = rt_q;
    wr_d   = wr_q;
    op_d   = op_q;
    exc_d  = exc_q;
    code_d = code_q;
    if (flush) begin
      pc_d   = '0;
      bd_d   = 1'b0;
      alu_d  = '0;
      rt_d   = '0;
      wr_d   = '0;
      op_d   = MEM_NONE;
      exc_d  = 1'b0;
      code_d = '0;
    end else if (!stall) begin
      // PC/BD/address still latched on a fault so CP0 can capture EPC and BadVAddr
      pc_d   = in_pc;
      bd_d   = in_bd;
      alu_d  = in_alu_res;
      rt_d   = in_rt_data;
      wr_d   = exc_now ? 5'd0 : in_wr_reg;
      op_d   = exc_now ? MEM_NONE : in_mem_op;
      exc_d  = exc_now;
      code_d = code_now;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= '0;
      bd_q   <= 1'b0;
      alu_q  <= '0;
      rt_q   <= '0;
      wr_q   <= '0;
      op_q   <= MEM_NONE;
      exc_q  <= 1'b0;
      code_q <= '0;
    end else begin
      pc_q   <= pc_d;
      bd_q   <= bd_d;
      alu_q  <= alu_d;
      rt_q   <= rt_d;
      wr_q   <= wr_d;
      op_q   <= op_d;
      exc_q  <= exc_d;
      code_q <= code_d;
    end
  end

  assign out_pc       = pc_q;
  assign out_bd       = bd_q;
  assign out_alu_res  = alu_q;
  assign out_rt_data  = rt_q;
  assign out_wr_reg   = wr_q;
  assign out_mem_op   = op_q;
  assign out_exc_vld  = exc_q;
  assign out_exc_code = code_q;

endmodule
